// File: rtl/hsstl_rst4mcrsw_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hsstl_rst4mcrsw_pkg
// Description : Shared state codes, default cycle constants and output-decode
//               helpers for the multi-lane RX reset controller.
// Revision    : 1.0 - initial release
// ============================================================================
package hsstl_rst4mcrsw_pkg;

    // Per-lane init FSM state codes (visible on the lane_fsm debug port)
    localparam logic [2:0] C_ST_IDLE       = 3'd0;
    localparam logic [2:0] C_ST_PMA_RST    = 3'd1;
    localparam logic [2:0] C_ST_CDR_WAIT   = 3'd2;
    localparam logic [2:0] C_ST_PCS_RST    = 3'd3;
    localparam logic [2:0] C_ST_ALIGN_WAIT = 3'd4;
    localparam logic [2:0] C_ST_DONE       = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE       = C_ST_IDLE,
        S_PMA_RST    = C_ST_PMA_RST,
        S_CDR_WAIT   = C_ST_CDR_WAIT,
        S_PCS_RST    = C_ST_PCS_RST,
        S_ALIGN_WAIT = C_ST_ALIGN_WAIT,
        S_DONE       = C_ST_DONE
    } lane_state_e;

    // Default cycle constants for silicon
    localparam int unsigned C_PMA_RST_CYCLES = 64;
    localparam int unsigned C_CDR_LOCK_HOLD  = 2048;
    localparam int unsigned C_CDR_TIMEOUT    = 65535;
    localparam int unsigned C_PCS_RST_CYCLES = 32;
    localparam int unsigned C_ALIGN_TIMEOUT  = 4095;
    localparam int unsigned C_CNTR_WIDTH     = 16;

    // Reduced CDR constants for accelerated simulation (SPEEDUP_SIM builds)
    localparam int unsigned C_SIM_CDR_LOCK_HOLD = 64;
    localparam int unsigned C_SIM_CDR_TIMEOUT   = 1024;

    // PMA RX reset is held only while the PMA itself is being reset or idle
    function automatic logic pma_rst_for(input lane_state_e s);
        return (s == S_IDLE) || (s == S_PMA_RST);
    endfunction

    // PCS RX reset is held until the PCS reset pulse has completed
    function automatic logic pcs_rst_for(input lane_state_e s);
        return (s == S_IDLE) || (s == S_PMA_RST) ||
               (s == S_CDR_WAIT) || (s == S_PCS_RST);
    endfunction

endpackage
`default_nettype wire

// File: rtl/hsstl_rst4mcrsw_sync_v1_0.sv
`default_nettype none
// ============================================================================
// Module      : hsstl_rst4mcrsw_sync_v1_0
// Description : Two-flop synchroniser for a single asynchronous status bit,
//               synchronous active-low reset to 0.
// Revision    : 1.0 - initial release
// ============================================================================
module hsstl_rst4mcrsw_sync_v1_0 (
    input  logic clk,
    input  logic rst_n,
    input  logic i_async,
    output logic o_sync
);

    logic meta_q;
    logic sync_q;

    // Two-stage capture of the asynchronous input into the clk domain
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= i_async;
            sync_q <= meta_q;
        end
    end

    assign o_sync = sync_q;

endmodule
`default_nettype wire

// File: rtl/hsstl_rst4mcrsw_rx_lane_init_fsm.sv
`default_nettype none
// ============================================================================
// Module      : hsstl_rst4mcrsw_rx_lane_init_fsm
// Description : Per-lane RX initialisation FSM. Sequences PMA RX reset, CDR
//               lock qualification, PCS RX reset and word-alignment wait, and
//               reports init_done to the multi-lane RX reset main FSM.
// Revision    : 1.0 - initial release
// ============================================================================
module hsstl_rst4mcrsw_rx_lane_init_fsm
    import hsstl_rst4mcrsw_pkg::*;
#(
    parameter int unsigned PMA_RST_CYCLES = C_PMA_RST_CYCLES,
    parameter int unsigned CDR_LOCK_HOLD  = C_CDR_LOCK_HOLD,
    parameter int unsigned CDR_TIMEOUT    = C_CDR_TIMEOUT,
    parameter int unsigned PCS_RST_CYCLES = C_PCS_RST_CYCLES,
    parameter int unsigned ALIGN_TIMEOUT  = C_ALIGN_TIMEOUT,
    parameter int unsigned CNTR_WIDTH     = C_CNTR_WIDTH
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       lane_powerup,
    input  logic       main_rst_align,
    input  logic       main_pll_loss_rst,
    input  logic       loss_of_signal,
    input  logic       cdr_lock,
    input  logic       word_align_done,
    output logic       P_RX_PMA_RST,
    output logic       P_PCS_RX_RST,
    output logic       init_done,
    output logic [2:0] lane_fsm
);

    // Terminal counter values; counters compare against these directly
    localparam logic [CNTR_WIDTH-1:0] C_PMA_LAST  = CNTR_WIDTH'(PMA_RST_CYCLES - 1);
    localparam logic [CNTR_WIDTH-1:0] C_LOCK_LAST = CNTR_WIDTH'(CDR_LOCK_HOLD - 1);
    localparam logic [CNTR_WIDTH-1:0] C_CDR_TMO   = CNTR_WIDTH'(CDR_TIMEOUT);
    localparam logic [CNTR_WIDTH-1:0] C_PCS_LAST  = CNTR_WIDTH'(PCS_RST_CYCLES - 1);
    localparam logic [CNTR_WIDTH-1:0] C_ALIGN_TMO = CNTR_WIDTH'(ALIGN_TIMEOUT);
    localparam logic [CNTR_WIDTH-1:0] C_CNT_MAX   = {CNTR_WIDTH{1'b1}};

    logic w_los_s;
    logic w_lock_s;
    logic w_align_s;

    lane_state_e            state_q, state_d;
    logic [CNTR_WIDTH-1:0]  cnt_q, cnt_d;
    logic [CNTR_WIDTH-1:0]  tmo_q, tmo_d;
    logic [CNTR_WIDTH-1:0]  w_cnt_inc;
    logic [CNTR_WIDTH-1:0]  w_tmo_inc;
    logic                   pma_rst_q;
    logic                   pcs_rst_q;
    logic                   init_done_q;

    hsstl_rst4mcrsw_sync_v1_0 u_sync_los (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_async (loss_of_signal),
        .o_sync  (w_los_s)
    );

    hsstl_rst4mcrsw_sync_v1_0 u_sync_lock (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_async (cdr_lock),
        .o_sync  (w_lock_s)
    );

    hsstl_rst4mcrsw_sync_v1_0 u_sync_align (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_async (word_align_done),
        .o_sync  (w_align_s)
    );

    // Next-state and counter logic: global exits override normal progression
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        tmo_d     = tmo_q;
        w_cnt_inc = (cnt_q == C_CNT_MAX) ? cnt_q : cnt_q + 1'b1;
        w_tmo_inc = (tmo_q == C_CNT_MAX) ? tmo_q : tmo_q + 1'b1;

        if (!lane_powerup) begin
            state_d = S_IDLE;
        end else if (w_los_s && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
        end else if (main_pll_loss_rst &&
                     (state_q inside {S_CDR_WAIT, S_PCS_RST, S_ALIGN_WAIT, S_DONE})) begin
            state_d = S_PMA_RST;
        end else if (!w_lock_s &&
                     (state_q inside {S_PCS_RST, S_ALIGN_WAIT, S_DONE})) begin
            state_d = S_PMA_RST;
        end else if (main_rst_align && (state_q inside {S_ALIGN_WAIT, S_DONE})) begin
            state_d = S_PCS_RST;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (!w_los_s) state_d = S_PMA_RST;
                end
                S_PMA_RST: begin
                    if (cnt_q == C_PMA_LAST) state_d = S_CDR_WAIT;
                    else                     cnt_d   = w_cnt_inc;
                end
                S_CDR_WAIT: begin
                    // Lock acceptance wins over the timeout in the same cycle
                    if (cnt_q == C_LOCK_LAST) begin
                        state_d = S_PCS_RST;
                    end else if (tmo_q == C_CDR_TMO) begin
                        state_d = S_PMA_RST;
                    end else begin
                        cnt_d = w_lock_s ? w_cnt_inc : '0;
                        tmo_d = w_tmo_inc;
                    end
                end
                S_PCS_RST: begin
                    if (cnt_q == C_PCS_LAST) state_d = S_ALIGN_WAIT;
                    else                     cnt_d   = w_cnt_inc;
                end
                S_ALIGN_WAIT: begin
                    if (w_align_s)                 state_d = S_DONE;
                    else if (cnt_q == C_ALIGN_TMO) state_d = S_PCS_RST;
                    else                           cnt_d   = w_cnt_inc;
                end
                S_DONE: begin
                    state_d = S_DONE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        // Any state change restarts both counters
        if (state_d != state_q) begin
            cnt_d = '0;
            tmo_d = '0;
        end
    end

    // State, counters and outputs registered together so outputs track state
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            tmo_q       <= '0;
            pma_rst_q   <= 1'b1;
            pcs_rst_q   <= 1'b1;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            tmo_q       <= tmo_d;
            pma_rst_q   <= pma_rst_for(state_d);
            pcs_rst_q   <= pcs_rst_for(state_d);
            init_done_q <= (state_d == S_DONE);
        end
    end

    assign P_RX_PMA_RST = pma_rst_q;
    assign P_PCS_RX_RST = pcs_rst_q;
    assign init_done    = init_done_q;
    assign lane_fsm     = state_q;

endmodule
`default_nettype wire
